// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add sequencer that drives one shared external full adder
module serial_add_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             fa_a_o,
  output logic             fa_b_o,
  output logic             fa_cin_o,
  input  logic             fa_s_i,
  input  logic             fa_cout_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH:0]   sum_o
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q;
  logic [WIDTH:0]   sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q;
  // The adder only sees operand bits while running; busy_q is exactly the RUN state
  assign fa_a_o   = busy_q & a_sh_q[0];
  assign fa_b_o   = busy_q & b_sh_q[0];
  assign fa_cin_o = busy_q & carry_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign sum_o    = sum_q;
  // Capture on start (IDLE or DONE), shift one bit per clock in RUN, publish on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (state_q == RUN) begin
      sum_sh_q <= {fa_s_i, sum_sh_q[WIDTH-1:1]};
      carry_q  <= fa_cout_i;
      a_sh_q   <= a_sh_q >> 1;
      b_sh_q   <= b_sh_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        sum_q   <= {fa_cout_i, fa_s_i, sum_sh_q[WIDTH-1:1]};
        state_q <= DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end else if (start_i) begin
      a_sh_q   <= acc_i ? sum_q[WIDTH-1:0] : a_i;
      b_sh_q   <= b_i;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_sh_q <= '0;
      state_q  <= RUN;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed stimulus with a queue scoreboard checked on each done pulse
module tb_serial_add_ctrl;
  localparam int W = 5;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0, acc_i = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic         fa_a_o, fa_b_o, fa_cin_o, fa_s_i, fa_cout_i;
  logic         busy_o, done_o;
  logic [W:0]   sum_o;
  int           total = 0, bad = 0;
  int           exp_q[$];
  logic [W-1:0] cin_log;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .acc_i(acc_i), .a_i(a_i), .b_i(b_i),
    .fa_a_o(fa_a_o), .fa_b_o(fa_b_o), .fa_cin_o(fa_cin_o), .fa_s_i(fa_s_i),
    .fa_cout_i(fa_cout_i), .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o)
  );

  assign fa_s_i    = fa_a_o ^ fa_b_o ^ fa_cin_o;
  assign fa_cout_i = (fa_a_o & fa_b_o) | (fa_cin_o & (fa_a_o ^ fa_b_o));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected sums on done, checks busy length, done width and idle adder drive
  int   busy_len = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_len = 0;
      prev_done = 1'b0;
    end else begin
      if (done_o) begin
        chk("done_width", int'(prev_done), 0);
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("sum", int'(sum_o), exp_q.pop_front());
      end
      if (busy_o) busy_len++;
      else if (busy_len != 0) begin
        chk("busy_len", busy_len, W);
        busy_len = 0;
      end
      if (!busy_o) chk("fa_idle", int'({fa_a_o, fa_b_o, fa_cin_o}), 0);
      chk("busy_done_excl", int'(busy_o & done_o), 0);
      prev_done = done_o;
    end
  end

  // One transaction: start for one edge, then wait (bounded) for done; optionally scramble inputs
  task automatic run(input int a, input int b, input bit acc, input int exp, input bit scramble);
    int k = 0;
    bit seen = 0;
    a_i = W'(a); b_i = W'(b); acc_i = acc; start_i = 1'b1;
    exp_q.push_back(exp);
    cin_log = '0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      start_i = 1'b0;
      acc_i = 1'b0;
      if (t == 0) chk("busy_start", int'(busy_o), 1);
      if (scramble) begin a_i = W'($urandom); b_i = W'($urandom); end
      if (busy_o && k < W) begin cin_log[k] = fa_cin_o; k++; end
      if (done_o) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sum", int'(sum_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run(21, 10, 0, 31, 0);
    @(negedge clk);
    run(31, 31, 0, 62, 0);
    chk("fa_cin_seq", int'(cin_log), 'b11110);
    @(negedge clk);
    run(7, 1, 1, 31, 0);
    run(7, 1, 1, 32, 0);
    @(negedge clk);
    a_i = 3; b_i = 4; acc_i = 1'b0; start_i = 1'b1;
    repeat (3) exp_q.push_back(7);
    repeat (18) @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_start_runs", exp_q.size(), 0);
    chk("held_sum", int'(sum_o), 7);
    a_i = 31; b_i = 1; start_i = 1'b1;
    repeat (3) begin @(negedge clk); start_i = 1'b0; end
    chk("pre_rst_busy", int'(busy_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", int'(sum_o), 0);
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_fa", int'({fa_a_o, fa_b_o, fa_cin_o}), 0);
    repeat (2) begin @(negedge clk); chk("mid_rst_done", int'(done_o), 0); end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", int'(done_o), 0);
    run(0, 0, 0, 0, 0);
    @(negedge clk);
    run(16, 15, 0, 31, 1);
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial sequencer for one shared full-adder cell. It streams two WIDTH-bit operands LSB-first through an external full adder, one bit per clock, and assembles a (WIDTH+1)-bit sum.
- Replaces a WIDTH-stage ripple chain with a single full adder plus this controller.
- Sits between switch/operand capture and LED display logic. Provides a start/busy/done handshake and an accumulate mode.

Parameters:
- WIDTH, 5, operand width in bits (legal range 2..16). Bit counter width is clog2(WIDTH+1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset; one clock domain, no other clocks
- start  input  1  request; sampled on the rising edge; level-sensitive
- acc  input  1  when sampled with an accepted start, operand A = sum[WIDTH-1:0] instead of a
- a  input  WIDTH  operand A, captured on an accepted start
- b  input  WIDTH  operand B, captured on an accepted start
- fa_a  output  1  to the shared full adder: current A bit
- fa_b  output  1  to the shared full adder: current B bit
- fa_cin  output  1  to the shared full adder: current carry
- fa_s  input  1  from the shared full adder: sum bit (combinational from fa_a/fa_b/fa_cin)
- fa_cout  input  1  from the shared full adder: carry out
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; high only in DONE
- sum  output  WIDTH+1  result register; bit WIDTH is the final carry

Behaviour:
- State machine has three states: IDLE, RUN, DONE.
- Reset (asynchronous, immediate on rst_n low, any state including mid-RUN):
  - state=IDLE, sum=0, busy=0, done=0.
  - Operand shift registers, carry register and bit counter all cleared.
  - fa_a=fa_b=fa_cin=0.
- IDLE:
  - start=0: remain in IDLE.
  - start=1 at an edge, accept:
    - a_sh <= (acc ? sum[WIDTH-1:0] : a); b_sh <= b.
    - carry <= 0; cnt <= 0; sum_sh <= 0; next state RUN.
- RUN, each edge:
  - sum_sh <= {fa_s, sum_sh[WIDTH-1:1]}.
  - carry <= fa_cout.
  - a_sh and b_sh shift right by 1, zero-fill.
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: sum <= {fa_cout, fa_s, sum_sh[WIDTH-1:1]}; next state DONE.
- Full-adder drive:
  - In RUN: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry, all combinational from registers.
  - In IDLE/DONE: all three are 0.
  - With carry=0 on bit 0, the full adder acts as a half adder for the LSB.
- DONE (one cycle):
  - done=1, busy=0.
  - Next state is IDLE.
  - If start=1 at that edge it is accepted exactly as in IDLE (back-to-back), going to RUN. The acc source is the just-written sum.
- Handshake and timing:
  - start accepted at edge E0.
  - busy is high for cycles E0..E0+WIDTH-1.
  - sum is updated at edge E0+WIDTH; done is high in the cycle following that edge.
  - Total latency: WIDTH+1 edges from acceptance to done falling.
- start in RUN is ignored; no queuing, no effect on operands.
- sum changes only at completion and at reset. It holds its value across IDLE and across a new RUN until the new result is written.
- Arithmetic:
  - Unsigned result: sum = A + B, exact in WIDTH+1 bits, no overflow flag.
  - In acc mode the previous carry (sum[WIDTH]) is discarded, i.e. A = sum mod 2^WIDTH.
- a and b may change freely after acceptance; only the captured copies are used.

Test Plan (WIDTH=5; bench models the full adder as s=a^b^cin, cout=(a&b)|(cin&(a^b))):
- Reset, then start with a=21, b=10, acc=0 -> busy high for 5 cycles; done pulses for 1 cycle; sum=6'd31; fa_* =0 outside RUN.
- a=31, b=31 -> sum=6'b111110 (62); fa_cin observed as 0,1,1,1,1 on the five RUN cycles.
- After sum=62, start with acc=1, b=1 -> A=30, sum=6'd31. Then start acc=1, b=1 again, back-to-back during DONE -> sum=6'd32, with no idle cycle between runs.
- Start held high continuously with a=3, b=4 -> runs repeat every 6 cycles; start pulses during RUN change nothing; sum=7 after each run.
- Assert rst_n low in the 3rd RUN cycle of a=31, b=1 -> state IDLE immediately, sum=0, busy=0, done stays 0. A fresh start with a=0, b=0 gives sum=0 with done pulse.
- Change a and b on every cycle during RUN of a=16, b=15 -> sum=31 (captured operands only).
